// File: rtl/ex_muldiv_seq_if.sv
// EX-stage <-> multiply/divide sequencer bundle: request, flush, stall and HI/LO result.
interface ex_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             div0_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  stall_o, busy_o, done_o, hi_o, lo_o, div0_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output stall_o, busy_o, done_o, hi_o, lo_o, div0_o
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Multi-cycle shift-add multiply / restoring divide beside the EX ALU.
// Optional MULDIV_EARLY_TERM_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module ex_muldiv_seq #(
  parameter int WIDTH      = 32,
  parameter int ITER_CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  ex_muldiv_seq_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(WIDTH - 1);
  localparam logic [ITER_CNT_W-1:0] ONE_CNT   = {{(ITER_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]      ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]      ONES_W    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]      ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0]    ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [WIDTH-1:0]        a_q, a_d, b_q, b_d;
  logic [WIDTH:0]          acc_q, acc_d;
  logic [WIDTH-1:0]        mq_q, mq_d;
  logic [WIDTH-1:0]        dvs_q, dvs_d;
  logic [ITER_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    res_neg_q, res_neg_d, rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]        hi_q, hi_d, lo_q, lo_d;
  logic                    div0_q, div0_d;

  logic                    is_div_s, is_sgn_s, run_last_s;
  logic [WIDTH:0]          mul_sum_s, div_rem_sh_s, div_trial_s;
  logic [2*WIDTH:0]        mul_shift_s;
  logic [2*WIDTH-1:0]      prod_raw_s, prod_s, prod_neg_s;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic is_sgn);
    abs_val = (is_sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    neg_if = neg ? (~v + ONE_W) : v;
  endfunction

  assign is_div_s     = op_q[1];
  assign is_sgn_s     = ~op_q[0];
  assign mul_sum_s    = mq_q[0] ? (acc_q + {1'b0, dvs_q}) : acc_q;
  assign mul_shift_s  = {mul_sum_s, mq_q} >> 1;
  assign div_rem_sh_s = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
  assign div_trial_s  = div_rem_sh_s - {1'b0, dvs_q};
  assign prod_raw_s   = {acc_q[WIDTH-1:0], mq_q};

`ifdef MULDIV_EARLY_TERM_EN
  // Bits above the current iteration still hold unprocessed multiplier bits.
  assign run_last_s = (cnt_q == LAST_ITER) ||
                      (!is_div_s && (((mq_q >> 1) & (ONES_W >> (cnt_q + ONE_CNT))) == ZERO_W));
  assign prod_s     = prod_raw_s >> (ITER_CNT_W'(WIDTH) - cnt_q);
`else
  assign run_last_s = (cnt_q == LAST_ITER);
  assign prod_s     = prod_raw_s;
`endif

  assign prod_neg_s = res_neg_q ? (~prod_s + ONE_2W) : prod_s;

  // Next-state and datapath sequencing.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div0_d    = div0_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          op_d    = bus.op_i;
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          div0_d  = 1'b0;
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_s) begin
            mq_d  = abs_val(a_q, is_sgn_s);
            dvs_d = abs_val(b_q, is_sgn_s);
          end else begin
            mq_d  = abs_val(b_q, is_sgn_s);
            dvs_d = abs_val(a_q, is_sgn_s);
          end
          acc_d     = {(WIDTH+1){1'b0}};
          cnt_d     = {ITER_CNT_W{1'b0}};
          res_neg_d = is_sgn_s & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rem_neg_d = is_sgn_s & a_q[WIDTH-1];
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_s) begin
            if (!div_trial_s[WIDTH]) begin
              acc_d = {1'b0, div_trial_s[WIDTH-1:0]};
              mq_d  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = div_rem_sh_s;
              mq_d  = {mq_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = mul_shift_s[2*WIDTH:WIDTH];
            mq_d  = mul_shift_s[WIDTH-1:0];
          end
          cnt_d   = cnt_q + ONE_CNT;
          state_d = run_last_s ? S_FIX : S_RUN;
        end
      end
      S_FIX: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_s) begin
            if (b_q == ZERO_W) begin
              lo_d   = ONES_W;
              hi_d   = a_q;
              div0_d = 1'b1;
            end else begin
              lo_d   = neg_if(mq_q, res_neg_q);
              hi_d   = neg_if(acc_q[WIDTH-1:0], rem_neg_q);
              div0_d = 1'b0;
            end
          end else begin
            hi_d = prod_neg_s[2*WIDTH-1:WIDTH];
            lo_d = prod_neg_s[WIDTH-1:0];
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      a_q       <= ZERO_W;
      b_q       <= ZERO_W;
      acc_q     <= {(WIDTH+1){1'b0}};
      mq_q      <= ZERO_W;
      dvs_q     <= ZERO_W;
      cnt_q     <= {ITER_CNT_W{1'b0}};
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= ZERO_W;
      lo_q      <= ZERO_W;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      div0_q    <= div0_d;
    end
  end

  // Stall covers the accepting cycle so EX holds until the result is in DONE.
  assign bus.stall_o = ((state_q == S_IDLE) && bus.start_i) || (state_q == S_PREP) ||
                       (state_q == S_RUN) || (state_q == S_FIX);
  assign bus.busy_o  = (state_q != S_IDLE);
  assign bus.done_o  = (state_q == S_DONE);
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
  assign bus.div0_o  = div0_q;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed + randomized bench for ex_muldiv_seq with a queue-based expected-result scoreboard.
module tb_ex_muldiv_seq;
  localparam logic [1:0] OP_MUL = 2'b00, OP_MULU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  ex_muldiv_seq_if #(.WIDTH(32)) bus ();

  ex_muldiv_seq #(.WIDTH(32), .ITER_CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
    int k;
    logic [31:0] m;
    k = 32;
    m = b;
`ifdef MULDIV_EARLY_TERM_EN
    if (!op[1]) begin
      if (!op[0] && b[31]) m = -b;
      k = 1;
      for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    end
`endif
    return k + 3;
  endfunction

  // Issue one op, push its expectation, wait for done_o and score it.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic ediv0,
                        input bit chk_stall);
    exp_t e;
    exp_t got_e;
    int   lat;
    bit   got;
    e.hi = ehi; e.lo = elo; e.div0 = ediv0; e.lat = exp_latency(op, b);
    sb_q.push_back(e);
    @(negedge clk);
    bus.op_i = op; bus.a_i = a; bus.b_i = b; bus.start_i = 1'b1;
    #1;
    if (chk_stall) check("stall_c0", {63'd0, bus.stall_o}, 64'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      lat++;
      if (lat == 1) check("div0_clr", {63'd0, bus.div0_o}, 64'd0);
      if (bus.done_o) got = 1'b1;
      else if (chk_stall && bus.stall_o !== 1'b1) check("stall_run", {63'd0, bus.stall_o}, 64'd1);
    end
    check("done_seen", {63'd0, got}, 64'd1);
    got_e = sb_q.pop_front();
    check("latency", 64'(lat), 64'(got_e.lat));
    if (chk_stall) check("stall_done", {63'd0, bus.stall_o}, 64'd0);
    check("hi", {32'd0, bus.hi_o}, {32'd0, got_e.hi});
    check("lo", {32'd0, bus.lo_o}, {32'd0, got_e.lo});
    check("div0", {63'd0, bus.div0_o}, {63'd0, got_e.div0});
  endtask

  task automatic watch_no_done(input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    check("no_done", {63'd0, seen}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, rhi, rlo;
    logic [1:0]  rop;
    logic [63:0] up;
    logic signed [63:0] sp;
    logic signed [31:0] sq, sr;

    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.op_i = 2'b00; bus.a_i = 32'd0; bus.b_i = 32'd0; bus.flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hi", {32'd0, bus.hi_o}, 64'd0);
    check("rst_lo", {32'd0, bus.lo_o}, 64'd0);
    check("rst_flags", {60'd0, bus.div0_o, bus.done_o, bus.busy_o, bus.stall_o}, 64'd0);
    rst_n = 1'b1;

    run_op(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1);
    run_op(OP_MUL,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
    run_op(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
    run_op(OP_DIVU, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op(OP_DIV,  32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op(OP_MULU, 32'd5,        32'd0,        32'd0,        32'd0,        1'b0, 1'b0);
    run_op(OP_MULU, 32'd5,        32'd3,        32'd0,        32'd15,       1'b0, 1'b0);
    run_op(OP_MULU, 32'd6,        32'd7,        32'd0,        32'd42,       1'b0, 1'b0);

    // Flush a DIVU 10 cycles after acceptance.
    @(negedge clk);
    bus.op_i = OP_DIVU; bus.a_i = 32'd9; bus.b_i = 32'd3; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_busy", {63'd0, bus.busy_o}, 64'd0);
    watch_no_done(40);
    check("flush_lo", {32'd0, bus.lo_o}, 64'd42);
    check("flush_hi", {32'd0, bus.hi_o}, 64'd0);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    bus.op_i = OP_MULU; bus.a_i = 32'd2; bus.b_i = 32'd2; bus.start_i = 1'b1; bus.flush_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    check("idle_flush_busy", {63'd0, bus.busy_o}, 64'd0);
    watch_no_done(40);
    check("idle_flush_lo", {32'd0, bus.lo_o}, 64'd42);

    // Reset in the middle of RUN.
    @(negedge clk);
    bus.op_i = OP_MULU; bus.a_i = 32'd7; bus.b_i = 32'd9; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_hi", {32'd0, bus.hi_o}, 64'd0);
    check("midrst_lo", {32'd0, bus.lo_o}, 64'd0);
    check("midrst_flags", {61'd0, bus.div0_o, bus.done_o, bus.busy_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done(40);

    // Randomized ops scored against native SV arithmetic.
    for (int i = 0; i < 8; i++) begin
      rop = 2'(i % 4);
      ra  = $urandom;
      rb  = $urandom;
      if (i >= 4) rb = (rb % 32'd50) + 32'd1;
      if (rb == 32'd0) rb = 32'd1;
      if (rop == OP_DIV && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      case (rop)
        OP_MULU: begin up = 64'(ra) * 64'(rb); rhi = up[63:32]; rlo = up[31:0]; end
        OP_MUL:  begin
          sp = 64'($signed(ra)) * 64'($signed(rb));
          rhi = sp[63:32]; rlo = sp[31:0];
        end
        OP_DIVU: begin rlo = ra / rb; rhi = ra % rb; end
        default: begin
          sq = $signed(ra) / $signed(rb); sr = $signed(ra) % $signed(rb);
          rlo = sq; rhi = sr;
        end
      endcase
      run_op(rop, ra, rb, rhi, rlo, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer attached beside the EX-stage ALU.
- Accepts one MUL/MULU/DIV/DIVU operation from EX and runs it as a 32-iteration shift-add multiply or restoring divide.
- Stalls the front of the pipeline while busy, then presents a 64-bit HI/LO result for one-cycle capture by the EX/MEM latch.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER_CNT_W, 6, width of the iteration counter; must hold WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start_i  in  1  request from EX; sampled only in IDLE.
- op_i  in  2  operation: 00 MUL (signed), 01 MULU, 10 DIV (signed), 11 DIVU.
- a_i  in  WIDTH  operand A, multiplicand or dividend.
- b_i  in  WIDTH  operand B, multiplier or divisor.
- flush_i  in  1  pipeline flush; aborts the operation in flight.
- stall_o  out  1  hold IF/ID/EX registers.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle result-valid pulse.
- hi_o  out  WIDTH  product high word, or remainder.
- lo_o  out  WIDTH  product low word, or quotient.
- div0_o  out  1  last divide had B == 0; valid with done_o.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - State goes to IDLE.
  - hi_o, lo_o, div0_o, done_o, busy_o all 0.
  - Reset applied mid-operation abandons the operation; no done_o follows.
- States: IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE.
- IDLE:
  - start_i = 1 latches op_i, a_i, b_i and moves to PREP.
  - start_i in any other state is ignored.
- PREP, 1 cycle:
  - For signed ops, take absolute values into the working registers.
  - Record result sign = sign(A) XOR sign(B), and remainder sign = sign(A).
  - Clear the iteration counter.
- RUN, exactly WIDTH cycles (iteration 0..WIDTH-1), then FIX.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper accumulator (WIDTH+1 bits including carry); then shift the accumulator:multiplier pair right by 1.
  - Divide: shift the remainder:quotient pair left by 1; trial-subtract the divisor from the remainder; if no borrow, keep the difference and set the quotient LSB to 1.
- FIX, 1 cycle:
  - Signed MUL: negate the 64-bit product if the result sign is 1.
  - Signed DIV: negate the quotient if the result sign is 1; negate the remainder if the remainder sign is 1.
  - Load hi_o/lo_o.
- DONE, 1 cycle: done_o = 1, then IDLE.
  - hi_o/lo_o hold their value until the next FIX.
- Latency: done_o is high exactly WIDTH+3 = 35 cycles after the cycle in which start_i was accepted.
- stall_o = (IDLE and start_i) or PREP or RUN or FIX.
  - stall_o is low in DONE, so EX/MEM captures the result while the pipeline advances.
- busy_o = state is not IDLE.
- Divide by zero:
  - Full latency is still used.
  - lo_o = all ones, hi_o = dividend as supplied (signed or unsigned), div0_o = 1.
  - div0_o is cleared by the next accepted start_i.
- Signed overflow, 0x80000000 / -1: lo_o = 0x80000000, hi_o = 0, div0_o = 0. This falls out naturally from the magnitude datapath.
- Zero operands take full latency.
- flush_i:
  - From PREP, RUN or FIX: state goes to IDLE at the next edge; hi_o/lo_o/div0_o are unchanged; no done_o.
  - In DONE: ignored, and done_o still pulses.
  - In IDLE: blocks acceptance of start_i in that cycle.
- Simultaneous rst_n = 0 and flush_i: reset wins.
- All arithmetic is modulo 2^WIDTH per word; there is no overflow flag for multiply.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined:
  - For MUL/MULU, RUN also exits to FIX at the end of any cycle in which the remaining unshifted multiplier bits are all zero.
  - The product is realigned in FIX by the remaining shift count.
  - Minimum RUN length is 1 cycle, so B == 0 gives done_o 4 cycles after start.
  - Divide timing is unchanged.
- Undefined: fixed 35-cycle latency for all ops; no realignment logic.

Test Plan:
- MULU a=0xFFFFFFFF b=0xFFFFFFFF -> done_o at start+35; hi_o=0xFFFFFFFE, lo_o=0x00000001; stall_o high for cycles 0..34, low at cycle 35.
- MUL a=0xFFFFFFFD (-3) b=7 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. Then DIV a=0x80000000 b=0xFFFFFFFF -> lo_o=0x80000000, hi_o=0, div0_o=0.
- DIVU a=100 b=0 -> done_o at start+35; lo_o=0xFFFFFFFF, hi_o=0x00000064, div0_o=1; next start clears div0_o.
- After a completed MULU 6x7 (lo_o=42), start DIVU 9/3 and assert flush_i 10 cycles later -> busy_o low next cycle, no done_o, lo_o stays 42. Then assert rst_n=0 mid-RUN of a new op -> all outputs 0, no done_o.
- With MULDIV_EARLY_TERM_EN: MULU a=5 b=0 -> done_o at start+4, hi_o=lo_o=0. MULU a=5 b=3 -> done_o at start+5, lo_o=15. Without the macro, both complete at start+35.
